// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/EXT memory port arbiter: FSM states, owner encoding
// and the legal read-latency range.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_EXT = 1'b1
   } owner_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of arbitrations EXT has lost; sat_o forces EXT to win next time.
module arb_wait_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sat_o = (cnt_q == CNT_W'(MAX_WAIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the core (fixed priority) and an
// external loader/debug port, one transaction in flight, with bounded EXT starvation.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int RD_LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam int LAT_W    = $clog2(RD_LAT_MAX + 1);

   state_t             state_q, state_d;
   owner_t             owner_q, owner_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               cpu_ack_q, cpu_ack_d;
   logic               ext_ack_q, ext_ack_d;
   logic [DATA_W-1:0]  cpu_rdata_q, ext_rdata_q;
   logic               capture;
   logic               any_req, ext_win, wait_sat, sel_we, in_idle;
   owner_t             winner;

   assign any_req = cpu_req | ext_req;
   assign ext_win = ext_req & (~cpu_req | wait_sat);
   assign winner  = ext_win ? OWN_EXT : OWN_CPU;
   assign sel_we  = ext_win ? ext_we : cpu_we;
   assign in_idle = (state_q == IDLE);

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (in_idle & ext_req & ~ext_win),
      .clr_i (~ext_req | (in_idle & ext_win)),
      .sat_o (wait_sat)
   );

   // Issue is combinational from the winner, and suppressed while reset is asserted.
   assign mem_en    = in_idle & any_req & ~reset;
   assign mem_we    = in_idle & any_req & sel_we & ~reset;
   assign mem_addr  = ext_win ? ext_addr : cpu_addr;
   assign mem_wdata = ext_win ? ext_wdata : cpu_wdata;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      lat_d     = lat_q;
      cpu_ack_d = 1'b0;
      ext_ack_d = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d = winner;
               if (sel_we) begin
                  state_d   = RESP;
                  cpu_ack_d = (winner == OWN_CPU);
                  ext_ack_d = (winner == OWN_EXT);
               end else begin
                  state_d = WAIT;
                  lat_d   = LAT_W'(1);
               end
            end
         end
         WAIT: begin
            if (lat_q == LAT_W'(RD_LAT_C)) begin
               capture   = 1'b1;
               state_d   = RESP;
               cpu_ack_d = (owner_q == OWN_CPU);
               ext_ack_d = (owner_q == OWN_EXT);
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         lat_q       <= '0;
         cpu_ack_q   <= 1'b0;
         ext_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_q     <= lat_d;
         cpu_ack_q <= cpu_ack_d;
         ext_ack_q <= ext_ack_d;
         if (capture && owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
         if (capture && owner_q == OWN_EXT) ext_rdata_q <= mem_rdata;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign ext_ack   = ext_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=2, MAX_WAIT=4) with a small
// latency-accurate memory model on the memory side.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we, ext_req, ext_we;
   logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
   logic [31:0] cpu_rdata, ext_rdata;
   logic        cpu_ack, ext_ack;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int en_cnt = 0;
   int e0;

   mem_port_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RD_LAT   (2),
      .MAX_WAIT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_rdata (ext_rdata),
      .ext_ack   (ext_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with two-cycle read latency; data is poisoned outside its valid cycle.
   logic [31:0] mem [0:255];
   logic        mem_init;
   logic        rd_v1, rd_v2;
   logic [7:0]  rd_a1;
   logic [31:0] rd_d2;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[4] <= 32'hDEADBEEF;
         rd_v1  <= 1'b0;
         rd_v2  <= 1'b0;
      end else begin
         rd_v1 <= mem_en & ~mem_we;
         rd_a1 <= mem_addr[9:2];
         rd_v2 <= rd_v1;
         rd_d2 <= mem[rd_a1];
         if (mem_en & mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = rd_v2 ? rd_d2 : 32'hBADBAD00;

   always @(posedge clk) if (mem_en) en_cnt <= en_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
      tick(); tick();
      cpu_req = 1'b1; cpu_addr = 32'h10; #1;
      chk("rst_mem_en", {31'b0, mem_en}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_cpu_ack", {31'b0, cpu_ack}, 0);
      chk("rst_ext_ack", {31'b0, ext_ack}, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_ext_rdata", ext_rdata, 0);

      // Test 1 / 6: CPU read of 0x10, req held through the ack cycle
      tick(); reset = 1'b0; mem_init = 1'b0; e0 = en_cnt; #1;
      chk("t1_issue_en", {31'b0, mem_en}, 1);
      chk("t1_issue_we", {31'b0, mem_we}, 0);
      chk("t1_issue_addr", mem_addr, 32'h10);
      tick(); #1;
      chk("t1_wait1_en", {31'b0, mem_en}, 0);
      chk("t1_wait1_ack", {31'b0, cpu_ack}, 0);
      tick(); #1;
      chk("t1_wait2_ack", {31'b0, cpu_ack}, 0);
      tick(); #1;
      chk("t1_ack", {31'b0, cpu_ack}, 1);
      chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("t1_resp_no_issue", {31'b0, mem_en}, 0);
      chk("t1_ext_ack", {31'b0, ext_ack}, 0);
      tick(); cpu_req = 1'b0; #1;
      chk("t1_ack_pulse", {31'b0, cpu_ack}, 0);
      tick(); #1;
      chk("t6_strobes", 32'(en_cnt - e0), 1);

      // Test 2: EXT write then EXT read back
      tick(); ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h00001234; #1;
      chk("t2_wr_en", {31'b0, mem_en}, 1);
      chk("t2_wr_we", {31'b0, mem_we}, 1);
      chk("t2_wr_addr", mem_addr, 32'h40);
      chk("t2_wr_wdata", mem_wdata, 32'h00001234);
      tick(); #1;
      chk("t2_wr_ack", {31'b0, ext_ack}, 1);
      chk("t2_wr_cpu_ack", {31'b0, cpu_ack}, 0);
      chk("t2_wr_resp_en", {31'b0, mem_en}, 0);
      tick(); ext_req = 1'b0; ext_we = 1'b0; #1;
      chk("t2_wr_ack_pulse", {31'b0, ext_ack}, 0);
      tick(); ext_req = 1'b1; #1;
      chk("t2_rd_en", {31'b0, mem_en}, 1);
      chk("t2_rd_we", {31'b0, mem_we}, 0);
      tick(); tick(); tick(); #1;
      chk("t2_rd_ack", {31'b0, ext_ack}, 1);
      chk("t2_rd_rdata", ext_rdata, 32'h00001234);
      chk("t2_cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
      tick(); ext_req = 1'b0; #1;

      // Test 3: simultaneous requests, CPU first, EXT after CPU's RESP
      tick(); cpu_req = 1'b1; cpu_addr = 32'h10; ext_req = 1'b1; ext_addr = 32'h40; #1;
      chk("t3_cpu_first_en", {31'b0, mem_en}, 1);
      chk("t3_cpu_first_addr", mem_addr, 32'h10);
      tick(); tick(); tick(); #1;
      chk("t3_cpu_ack", {31'b0, cpu_ack}, 1);
      chk("t3_ext_ack_early", {31'b0, ext_ack}, 0);
      tick(); cpu_req = 1'b0; #1;
      chk("t3_ext_issue_en", {31'b0, mem_en}, 1);
      chk("t3_ext_issue_addr", mem_addr, 32'h40);
      tick(); tick(); tick(); #1;
      chk("t3_ext_ack", {31'b0, ext_ack}, 1);
      chk("t3_ext_rdata", ext_rdata, 32'h00001234);
      chk("t3_cpu_ack_late", {31'b0, cpu_ack}, 0);
      tick(); ext_req = 1'b0; #1;

      // Test 4: starvation bound with back-to-back CPU reads
      tick(); cpu_req = 1'b1; cpu_addr = 32'h10; ext_req = 1'b1; ext_addr = 32'h40; e0 = en_cnt; #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_cpu_win%0d_en", i), {31'b0, mem_en}, 1);
         chk($sformatf("t4_cpu_win%0d_addr", i), mem_addr, 32'h10);
         tick(); tick(); tick(); #1;
         chk($sformatf("t4_cpu_ack%0d", i), {31'b0, cpu_ack}, 1);
         chk($sformatf("t4_ext_idle%0d", i), {31'b0, ext_ack}, 0);
         tick(); #1;
      end
      chk("t4_ext_forced_en", {31'b0, mem_en}, 1);
      chk("t4_ext_forced_addr", mem_addr, 32'h40);
      tick(); tick(); tick(); #1;
      chk("t4_ext_ack", {31'b0, ext_ack}, 1);
      chk("t4_cpu_ack_none", {31'b0, cpu_ack}, 0);
      tick(); #1;
      chk("t4_cnt_cleared_addr", mem_addr, 32'h10);
      chk("t4_cnt_cleared_en", {31'b0, mem_en}, 1);
      tick(); tick(); tick(); #1;
      chk("t4_last_cpu_ack", {31'b0, cpu_ack}, 1);
      tick(); cpu_req = 1'b0; ext_req = 1'b0; #1;
      chk("t4_strobes", 32'(en_cnt - e0), 6);

      // Test 5: reset during the WAIT phase of a CPU read
      tick(); cpu_req = 1'b1; cpu_addr = 32'h10; #1;
      chk("t5_issue_en", {31'b0, mem_en}, 1);
      tick(); reset = 1'b1; cpu_req = 1'b0; #1;
      chk("t5_rst_en", {31'b0, mem_en}, 0);
      tick(); reset = 1'b0; #1;
      chk("t5_post_cpu_ack", {31'b0, cpu_ack}, 0);
      chk("t5_post_ext_ack", {31'b0, ext_ack}, 0);
      chk("t5_post_cpu_rdata", cpu_rdata, 0);
      chk("t5_post_ext_rdata", ext_rdata, 0);
      chk("t5_post_en", {31'b0, mem_en}, 0);
      tick(); #1;
      chk("t5_no_ack_a", {31'b0, cpu_ack}, 0);
      tick(); #1;
      chk("t5_no_ack_b", {31'b0, cpu_ack}, 0);
      tick(); cpu_req = 1'b1; cpu_addr = 32'h40; #1;
      chk("t5_new_en", {31'b0, mem_en}, 1);
      tick(); tick(); tick(); #1;
      chk("t5_new_ack", {31'b0, cpu_ack}, 1);
      chk("t5_new_rdata", cpu_rdata, 32'h00001234);
      tick(); cpu_req = 1'b0; #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
